wgt_feeder: RTL
===============

// Module: wgt_feeder
// PURPOSE
//  Upstream stage of the per-row weight shift buffers. Accepts a raster-order KSIZExKSIZE int8 kernel
//  from the DMA over valid/ready into one of two ping-pong banks. On request, replays one full kernel
//  into KSIZE parallel shift-buffer lanes: KSIZE shift cycles, one kernel column per cycle.
//  Shares the array's stall, so a weight shifts downstream only when wgt_read=1 and stall=0.
// PARAMETERS
//  KSIZE  3  kernel height/width; also the number of output lanes and shift cycles per feed
//  DW     8  weight width in bits (signed)
// PORTS
//  clk        in   1         clock
//  rst_n      in   1         reset, asynchronous, active-low
//  stall      in   1         pipeline stall (same net as the downstream shift buffers)
//  in_valid   in   1         DMA weight valid
//  in_data    in   DW        DMA weight, signed, row-major order w[r][c]
//  in_ready   out  1         feeder can accept in_data this cycle
//  feed_req   in   1         1-cycle pulse: push the next full kernel to the lanes
//  wgt_read   out  1         shift enable to all lanes (registered)
//  wgt_out    out  KSIZE*DW  lane r at bits [r*DW +: DW] = w[r][col] (registered)
//  feed_busy  out  1         high from request acceptance until feed_done
//  feed_done  out  1         1-cycle pulse after the last column has shifted
//  bank_full  out  2         per-bank full flags (debug/status)
// BEHAVIOUR
//  Reset: all outputs 0; bank_full=0; wr_bank=rd_bank=0; state IDLE; pending=0; in_ready=1 after reset.
//  Load side (ignores stall):
//   - in_ready = !bank_full[wr_bank]. A beat transfers when in_valid && in_ready.
//   - Beat k (0..KSIZE*KSIZE-1) is stored at row k/KSIZE, col k%KSIZE.
//   - On beat KSIZE*KSIZE-1: set bank_full[wr_bank], toggle wr_bank, clear the beat counter.
//   - With both banks full, in_ready=0 until a feed releases a bank.
//  Feed FSM, states IDLE, WAIT, FEED:
//   - IDLE: on feed_req, or when pending=1, clear pending.
//     Go to FEED if bank_full[rd_bank], else to WAIT. feed_busy=1 from the next cycle.
//   - WAIT: go to FEED in the cycle bank_full[rd_bank] is seen high.
//   - Entering FEED: register wgt_read=1, wgt_out=column 0, col=0.
//   - FEED, cycle with stall=0: the lanes capture the current column. If col<KSIZE-1,
//     register column col+1 and increment col.
//     If col==KSIZE-1: wgt_read<=0, clear bank_full[rd_bank], toggle rd_bank, pulse feed_done, go IDLE.
//   - FEED, cycle with stall=1: hold wgt_read, wgt_out and col unchanged.
//   - Result after a feed: lane r holds buf[KSIZE-1]=w[r][0] .. buf[0]=w[r][KSIZE-1].
//   - Latency: feed_req at edge t with a full bank and no stall -> wgt_read high for
//     KSIZE cycles starting at t+1; feed_done at t+KSIZE+1.
//   - wgt_out holds its last value when wgt_read=0.
//  Boundaries:
//   - feed_req while in WAIT/FEED sets pending (one deep); extra requests are dropped.
//   - A feed_req in the same cycle as feed_done is recorded in pending.
//   - Load completion of one bank and feed release of the other in the same cycle both take
//     effect. The same bank never sees both: the writer only writes non-full banks, the reader
//     only reads full banks.
//   - A bank released by feed_done is writable the next cycle (in_ready can rise at t+KSIZE+2).
//   - Stall during WAIT has no effect. Stall never blocks loading.
//   - rst_n low mid-load or mid-feed: immediate return to reset values; partial kernels are discarded.
// STRUCTURE
//  - Shared package: DW, KSIZE, FSM state encoding (IDLE=0, WAIT=1, FEED=2),
//    and a lane slice helper/localparam LANE_W=DW.
//  - One sub-module: wgt_bank_rf (2 x KSIZE*KSIZE x DW register file, 1 write port,
//    KSIZE-wide column read port by bank/col).
//  - FSM, counters and flags stay in wgt_feeder.
// TESTING
//  - Reset, then load w[r][c]=10*r+c (9 beats), then feed_req -> wgt_read high 3 cycles.
//    Lane outputs (0,10,20),(1,11,21),(2,12,22); feed_done 1 cycle later.
//    Downstream buffers end with buf2=10r, buf0=10r+2.
//  - Stall=1 for 2 cycles during column 1 -> wgt_out frozen at (1,11,21),
//    wgt_read stays 1, feed_done delayed by exactly 2 cycles.
//  - Load 18 beats back-to-back with a 19th valid pending -> in_ready=0 after beat 18,
//    bank_full=2'b11. One feed -> in_ready rises the cycle after feed_done.
//  - feed_req with both banks empty -> WAIT, feed_busy=1, wgt_read=0. Completing a 9-beat load
//    -> FEED entered the following cycle with column 0 of that kernel.
//  - feed_req twice during a FEED -> exactly one extra feed runs (pending); the third request is dropped.
//  - rst_n low during column 1 of a feed with one bank loading -> all outputs 0, bank_full=0,
//    in_ready=1 at release; a subsequent 9-beat load and feed behave as in test 1.

Source files
------------

// File: rtl/wgt_feeder_pkg.sv
// Shared constants, FSM encoding and lane helpers for the weight feeder.
package wgt_feeder_pkg;

  localparam int unsigned KSIZE      = 3;
  localparam int unsigned DW         = 8;
  localparam int unsigned LANE_W     = DW;
  localparam int unsigned NBEAT      = KSIZE * KSIZE;
  localparam int unsigned BEAT_W     = $clog2(NBEAT);
  localparam int unsigned COL_W      = (KSIZE > 1) ? $clog2(KSIZE) : 1;
  localparam int unsigned LANES_W    = KSIZE * LANE_W;
  localparam int unsigned LANE_IDX_W = $clog2(LANES_W);

  // One kernel column, lane r at bits [r*LANE_W +: LANE_W]
  typedef logic [LANES_W-1:0] lanes_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_FEED = 2'd2
  } feed_state_t;

  // Extract lane r from a packed column
  function automatic logic [LANE_W-1:0] lane_slice(input lanes_t v, input int unsigned r);
    return v[LANE_IDX_W'(r * LANE_W) +: LANE_W];
  endfunction

endpackage

// File: rtl/wgt_feeder_if.sv
// DMA load stream, feed request and lane-side outputs of the weight feeder.
interface wgt_feeder_if;
  import wgt_feeder_pkg::*;

  logic                 in_valid;
  logic signed [DW-1:0] in_data;
  logic                 in_ready;
  logic                 feed_req;
  logic                 wgt_read;
  lanes_t               wgt_out;
  logic                 feed_busy;
  logic                 feed_done;
  logic [1:0]           bank_full;

  modport master (
    output in_valid, in_data, feed_req,
    input  in_ready, wgt_read, wgt_out, feed_busy, feed_done, bank_full
  );

  modport slave (
    input  in_valid, in_data, feed_req,
    output in_ready, wgt_read, wgt_out, feed_busy, feed_done, bank_full
  );

endinterface

// File: rtl/wgt_bank_rf.sv
// Two-bank kernel store: raster-order write port, one-column-wide read port.
module wgt_bank_rf
  import wgt_feeder_pkg::*;
(
  input  logic              clk,
  input  logic              we,
  input  logic              wbank,
  input  logic [BEAT_W-1:0] waddr,
  input  logic [DW-1:0]     wdata,
  input  logic              rbank,
  input  logic [COL_W-1:0]  rcol,
  output lanes_t            rdata_c
);

  logic [DW-1:0] mem [2][NBEAT];

  // Write one raster-order beat into the selected bank
  always_ff @(posedge clk) begin
    if (we) begin
      mem[wbank][waddr] <= wdata;
    end
  end

  // Gather column rcol: lane r reads element r*KSIZE+rcol
  always_comb begin
    rdata_c = '0;
    for (int r = 0; r < KSIZE; r++) begin
      rdata_c[LANE_IDX_W'(r * LANE_W) +: LANE_W] =
        mem[rbank][BEAT_W'(r * KSIZE) + BEAT_W'(rcol)];
    end
  end

endmodule

// File: rtl/wgt_feeder.sv
// Ping-pong kernel loader and column-by-column replay into the weight lanes.
module wgt_feeder
  import wgt_feeder_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  wgt_feeder_if.slave bus
);

  feed_state_t       state_q, state_d;
  logic [1:0]        bank_full_q, bank_full_d;
  logic              wr_bank_q, wr_bank_d;
  logic              rd_bank_q, rd_bank_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic              pending_q, pending_d;
  logic              wgt_read_q, wgt_read_d;
  lanes_t            wgt_out_q;
  logic              feed_busy_q, feed_busy_d;
  logic              feed_done_q, feed_done_d;
  logic              in_ready_q, in_ready_d;

  logic              wr_fire_c;
  logic              load_last_c;
  logic              start_c;
  logic              rd_full_c;
  logic              col_last_c;
  logic              load_col_c;
  logic              release_c;
  lanes_t            rf_col_c;

  assign wr_fire_c   = bus.in_valid & in_ready_q;
  assign load_last_c = wr_fire_c & (beat_q == BEAT_W'(NBEAT - 1));
  assign start_c     = bus.feed_req | pending_q;
  assign rd_full_c   = bank_full_q[rd_bank_q];
  assign col_last_c  = (col_q == COL_W'(KSIZE - 1));

  wgt_bank_rf u_rf (
    .clk     (clk),
    .we      (wr_fire_c),
    .wbank   (wr_bank_q),
    .waddr   (beat_q),
    .wdata   (bus.in_data),
    .rbank   (rd_bank_q),
    .rcol    (col_d),
    .rdata_c (rf_col_c)
  );

  // Load side: beat counter, bank fill and write-bank toggle; ignores stall
  always_comb begin
    beat_d      = beat_q;
    wr_bank_d   = wr_bank_q;
    bank_full_d = bank_full_q;
    if (wr_fire_c) begin
      beat_d = load_last_c ? '0 : beat_q + BEAT_W'(1);
    end
    if (load_last_c) begin
      bank_full_d[wr_bank_q] = 1'b1;
      wr_bank_d              = ~wr_bank_q;
    end
    if (release_c) begin
      bank_full_d[rd_bank_q] = 1'b0;
    end
    // A bank released this cycle becomes writable one cycle later
    in_ready_d = ~bank_full_q[wr_bank_d];
  end

  // Feed FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Feed FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start_c)    state_d = rd_full_c ? ST_FEED : ST_WAIT;
      ST_WAIT: if (rd_full_c)  state_d = ST_FEED;
      ST_FEED: if (!stall && col_last_c) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Feed FSM outputs: column sequencing, request queueing, done/release
  always_comb begin
    pending_d   = pending_q;
    col_d       = col_q;
    wgt_read_d  = wgt_read_q;
    feed_busy_d = feed_busy_q;
    feed_done_d = 1'b0;
    load_col_c  = 1'b0;
    release_c   = 1'b0;
    rd_bank_d   = rd_bank_q;
    case (state_q)
      ST_IDLE: begin
        if (start_c) begin
          pending_d   = 1'b0;
          feed_busy_d = 1'b1;
          if (rd_full_c) begin
            wgt_read_d = 1'b1;
            col_d      = '0;
            load_col_c = 1'b1;
          end
        end
      end
      ST_WAIT: begin
        if (bus.feed_req) pending_d = 1'b1;
        if (rd_full_c) begin
          wgt_read_d = 1'b1;
          col_d      = '0;
          load_col_c = 1'b1;
        end
      end
      ST_FEED: begin
        if (bus.feed_req) pending_d = 1'b1;
        if (!stall) begin
          if (col_last_c) begin
            wgt_read_d  = 1'b0;
            feed_done_d = 1'b1;
            feed_busy_d = 1'b0;
            release_c   = 1'b1;
            rd_bank_d   = ~rd_bank_q;
          end else begin
            col_d      = col_q + COL_W'(1);
            load_col_c = 1'b1;
          end
        end
      end
      default: begin
        wgt_read_d  = 1'b0;
        feed_busy_d = 1'b0;
      end
    endcase
  end

  // Datapath and status registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_full_q <= '0;
      wr_bank_q   <= 1'b0;
      rd_bank_q   <= 1'b0;
      beat_q      <= '0;
      col_q       <= '0;
      pending_q   <= 1'b0;
      wgt_read_q  <= 1'b0;
      wgt_out_q   <= '0;
      feed_busy_q <= 1'b0;
      feed_done_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      bank_full_q <= bank_full_d;
      wr_bank_q   <= wr_bank_d;
      rd_bank_q   <= rd_bank_d;
      beat_q      <= beat_d;
      col_q       <= col_d;
      pending_q   <= pending_d;
      wgt_read_q  <= wgt_read_d;
      feed_busy_q <= feed_busy_d;
      feed_done_q <= feed_done_d;
      in_ready_q  <= in_ready_d;
      if (load_col_c) begin
        wgt_out_q <= rf_col_c;
      end
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.wgt_read  = wgt_read_q;
  assign bus.wgt_out   = wgt_out_q;
  assign bus.feed_busy = feed_busy_q;
  assign bus.feed_done = feed_done_q;
  assign bus.bank_full = bank_full_q;

endmodule
